// File: rtl/multi_pulse_pkg.sv
// Shared types for the multi-channel PPS-aligned pulse generator:
// controller state encoding and the packed time-of-day field layout.
package multi_pulse_pkg;

    localparam int TIME_W    = 56;
    localparam int SEC_LSB   = 0;
    localparam int SEC_W     = 8;
    localparam int MIN_LSB   = 8;
    localparam int MIN_W     = 8;
    localparam int HOUR_LSB  = 16;
    localparam int HOUR_W    = 8;
    localparam int DAY_LSB   = 24;
    localparam int DAY_W     = 8;
    localparam int MONTH_LSB = 32;
    localparam int MONTH_W   = 8;
    localparam int YEAR_LSB  = 40;
    localparam int YEAR_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TIME = 2'd1,
        ST_WAIT_PPS  = 2'd2,
        ST_RUN       = 2'd3
    } mp_state_e;

    function automatic logic time_match(input logic [TIME_W-1:0] a,
                                        input logic [TIME_W-1:0] b);
        return (a[YEAR_LSB  +: YEAR_W]  == b[YEAR_LSB  +: YEAR_W])  &&
               (a[MONTH_LSB +: MONTH_W] == b[MONTH_LSB +: MONTH_W]) &&
               (a[DAY_LSB   +: DAY_W]   == b[DAY_LSB   +: DAY_W])   &&
               (a[HOUR_LSB  +: HOUR_W]  == b[HOUR_LSB  +: HOUR_W])  &&
               (a[MIN_LSB   +: MIN_W]   == b[MIN_LSB   +: MIN_W])   &&
               (a[SEC_LSB   +: SEC_W]   == b[SEC_LSB   +: SEC_W]);
    endfunction

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: phase delay, then a period/width microsecond counter
// with an optional finite pulse count. Config is latched on start.
module pulse_channel
    import multi_pulse_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_start,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_width_high,
    input  logic [CNT_W-1:0] i_width_period,
    input  logic [CNT_W-1:0] i_phase_offset,
    input  logic [CNT_W-1:0] i_pulse_count,
    output logic             o_pulse,
    output logic             o_running
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] width_q, width_d, period_q, period_d, count_q, count_d;
    logic [CNT_W-1:0] phase_q, phase_d, micro_q, micro_d, pcount_q, pcount_d;
    logic [CNT_W-1:0] period_eff;
    logic             running_q, running_d, pulse_q, pulse_d;

    always_comb begin
        width_d    = width_q;
        period_d   = period_q;
        count_d    = count_q;
        phase_d    = phase_q;
        micro_d    = micro_q;
        pcount_d   = pcount_q;
        running_d  = running_q;
        period_eff = (period_q == '0) ? ONE : period_q;

        if (!i_enable) begin
            phase_d   = '0;
            micro_d   = '0;
            pcount_d  = '0;
            running_d = 1'b0;
        end else if (i_start) begin
            width_d   = i_width_high;
            period_d  = i_width_period;
            count_d   = i_pulse_count;
            phase_d   = i_phase_offset;
            micro_d   = '0;
            pcount_d  = '0;
            running_d = 1'b1;
        end else if (running_q && i_tick) begin
            if (phase_q != '0) begin
                phase_d = phase_q - ONE;
            end else if (micro_q >= period_eff - ONE) begin
                micro_d  = '0;
                pcount_d = pcount_q + ONE;
                if ((count_q != '0) && (pcount_d == count_q)) begin
                    running_d = 1'b0;
                end
            end else begin
                micro_d = micro_q + ONE;
            end
        end

        pulse_d = i_enable && running_q && (phase_q == '0) && (micro_q < width_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            width_q   <= '0;
            period_q  <= '0;
            count_q   <= '0;
            phase_q   <= '0;
            micro_q   <= '0;
            pcount_q  <= '0;
            running_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            width_q   <= width_d;
            period_q  <= period_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
            micro_q   <= micro_d;
            pcount_q  <= pcount_d;
            running_q <= running_d;
            pulse_q   <= pulse_d;
        end
    end

    assign o_pulse   = pulse_q;
    assign o_running = running_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// Multi-channel PPS-aligned pulse generator: arm / time-match / PPS-wait
// controller plus NUM_CH channels. MULTI_PULSE_PPS_RESYNC_EN re-aligns the us tick to PPS in RUN.
//
// state        | meaning
// ST_IDLE      | no channel enabled or run finished
// ST_WAIT_TIME | armed, waiting for Thunderbolt time == start time
// ST_WAIT_PPS  | time matched, waiting for the next PPS edge
// ST_RUN       | channels counting
module multi_pulse_generator
    import multi_pulse_pkg::*;
#(
    parameter int CLKS_PER_1_US = 10,
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_pps_raw,
    input  logic [NUM_CH-1:0]       i_pulse_enable,
    input  logic [TIME_W-1:0]       i_usr_time,
    input  logic                    i_thunder_packet_dv,
    input  logic [TIME_W-1:0]       i_thunder_time,
    input  logic [NUM_CH*CNT_W-1:0] i_width_high,
    input  logic [NUM_CH*CNT_W-1:0] i_width_period,
    input  logic [NUM_CH*CNT_W-1:0] i_phase_offset,
    input  logic [NUM_CH*CNT_W-1:0] i_pulse_count,
    output logic [NUM_CH-1:0]       o_pulse_out,
    output logic                    o_armed,
    output logic [NUM_CH-1:0]       o_running
);

    localparam int             CW   = (CLKS_PER_1_US > 1) ? $clog2(CLKS_PER_1_US) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_1_US - 1);

    mp_state_e     state_q, state_d;
    logic [1:0]    pps_q;
    logic          pps_edge;
    logic          start_q, start_d, tick_q, tick_d;
    logic [CW-1:0] us_cnt_q, us_cnt_d;

    assign pps_edge = (pps_q == 2'b01);

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE:      if (|i_pulse_enable) state_d = ST_WAIT_TIME;
            ST_WAIT_TIME: if (i_thunder_packet_dv && time_match(i_thunder_time, i_usr_time))
                              state_d = ST_WAIT_PPS;
            ST_WAIT_PPS:  if (pps_edge) begin
                              state_d = ST_RUN;
                              start_d = 1'b1;
                          end
            // channels latch one cycle after RUN entry, so ignore the empty running vector then
            ST_RUN:       if (!start_q && (o_running == '0)) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        if (i_pulse_enable == '0) begin
            state_d = ST_IDLE;
            start_d = 1'b0;
        end
    end

    // Tick is registered so channel updates line up with the registered start.
    always_comb begin
        us_cnt_d = '0;
        tick_d   = (state_q == ST_RUN) && (us_cnt_q == LAST);
        if (state_q == ST_RUN) begin
            us_cnt_d = (us_cnt_q == LAST) ? '0 : us_cnt_q + CW'(1);
`ifdef MULTI_PULSE_PPS_RESYNC_EN
            if (pps_edge) us_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            pps_q    <= 2'b00;
            start_q  <= 1'b0;
            tick_q   <= 1'b0;
            us_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pps_q    <= {pps_q[0], i_pps_raw};
            start_q  <= start_d;
            tick_q   <= tick_d;
            us_cnt_q <= us_cnt_d;
        end
    end

    assign o_armed = (state_q == ST_WAIT_TIME) || (state_q == ST_WAIT_PPS);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pulse_channel #(.CNT_W(CNT_W)) u_ch (
            .i_clk          (i_clk),
            .i_rst_n        (i_rst_n),
            .i_tick         (tick_q),
            .i_start        (start_q),
            .i_enable       (i_pulse_enable[k]),
            .i_width_high   (i_width_high[k*CNT_W +: CNT_W]),
            .i_width_period (i_width_period[k*CNT_W +: CNT_W]),
            .i_phase_offset (i_phase_offset[k*CNT_W +: CNT_W]),
            .i_pulse_count  (i_pulse_count[k*CNT_W +: CNT_W]),
            .o_pulse        (o_pulse_out[k]),
            .o_running      (o_running[k])
        );
    end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator (2 channels, 10 clk/us) with
// hand-computed edge positions relative to the edge that samples PPS high.
module tb_multi_pulse_generator;

    localparam int NCH = 2;
    localparam int CW  = 24;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pps = 1'b0;
    logic [NCH-1:0]  en = '0;
    logic [55:0]     usr = 56'h07E8_0C_1F_17_3B_00;
    logic [55:0]     thtime = '0;
    logic            dv = 1'b0;
    logic [NCH*CW-1:0] wh = '0, wp = '0, ph = '0, pc = '0;
    logic [NCH-1:0]  pout, prun;
    logic            armed;

    logic [NCH-1:0]  outs [0:400];
    logic [NCH-1:0]  runs [0:400];
    int checks = 0;
    int failures = 0;
    int guard;

    always #5 clk = ~clk;

    multi_pulse_generator #(.CLKS_PER_1_US(10), .NUM_CH(NCH), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pps_raw(pps), .i_pulse_enable(en),
        .i_usr_time(usr), .i_thunder_packet_dv(dv), .i_thunder_time(thtime),
        .i_width_high(wh), .i_width_period(wp), .i_phase_offset(ph),
        .i_pulse_count(pc), .o_pulse_out(pout), .o_armed(armed), .o_running(prun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int k, input int w, input int p, input int phs, input int c);
        wh[k*CW +: CW] = CW'(w);
        wp[k*CW +: CW] = CW'(p);
        ph[k*CW +: CW] = CW'(phs);
        pc[k*CW +: CW] = CW'(c);
    endtask

    // leaves PPS high; the last step is the edge that first samples it high
    task automatic pps_fire();
        pps = 1'b0;
        step(2);
        pps = 1'b1;
        step(1);
    endtask

    task automatic arm();
        step(1);
        thtime = usr;
        dv = 1'b1;
        step(1);
        dv = 1'b0;
        check("armed_before_pps", armed, 1);
        pps_fire();
    endtask

    task automatic capture(input int n);
        outs[0] = '0;
        for (int i = 1; i <= n; i++) begin
            step(1);
            outs[i] = pout;
            runs[i] = prun;
        end
    endtask

    function automatic int first_rise(input int k, input int n);
        for (int i = 1; i <= n; i++)
            if (outs[i][k] && !outs[i-1][k]) return i;
        return -1;
    endfunction

    function automatic int high_cnt(input int k, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (outs[i][k]) c++;
        return c;
    endfunction

    task automatic disarm();
        en = '0;
        step(2);
        check("disarm_armed_low", armed, 0);
    endtask

    initial begin
        step(2);
        check("rst_pulse", pout, 0);
        check("rst_running", prun, 0);
        check("rst_armed", armed, 0);
        rst_n = 1'b1;

        // continuous ch0 and phased, finite ch1
        cfg(0, 3, 10, 0, 0);
        cfg(1, 2, 4, 5, 3);
        en = 2'b11;
        arm();
        capture(400);
        check("ch0_first_rise", first_rise(0, 400), 3);
        check("ch0_high_first_period", high_cnt(0, 3, 102), 30);
        check("ch0_last_high", outs[32][0], 1);
        check("ch0_first_low", outs[33][0], 0);
        check("ch0_second_rise", outs[103][0] && !outs[102][0], 1);
        check("ch1_first_rise", first_rise(1, 400), 53);
        check("ch1_total_high", high_cnt(1, 1, 400), 60);
        check("ch1_third_pulse_end", {outs[152][1], outs[153][1]}, 2'b10);
        check("ch1_running_before_end", runs[171][1], 1);
        check("ch1_running_after_end", runs[172][1], 0);
        check("ch0_still_running", runs[400][0], 1);
        disarm();

        // mismatching time then PPS: stays armed, no output
        cfg(0, 3, 10, 0, 0);
        cfg(1, 0, 4, 0, 0);
        en = 2'b11;
        step(1);
        thtime = usr ^ 56'h1;
        dv = 1'b1;
        step(1);
        dv = 1'b0;
        pps_fire();
        capture(40);
        check("mismatch_no_pulses", high_cnt(0, 1, 40) + high_cnt(1, 1, 40), 0);
        check("mismatch_still_armed", armed, 1);
        arm();
        capture(120);
        check("match_ch0_first_rise", first_rise(0, 120), 3);
        check("width0_ch1_low", high_cnt(1, 1, 120), 0);
        disarm();

        // width==period -> constant high; period 0 -> 1 us with 5 pulses
        cfg(0, 10, 10, 0, 0);
        cfg(1, 1, 0, 0, 5);
        en = 2'b11;
        arm();
        capture(200);
        check("const_high_cnt", high_cnt(0, 1, 200), 198);
        check("period0_high_cnt", high_cnt(1, 1, 200), 50);
        check("period0_running_51", runs[51][1], 1);
        check("period0_running_52", runs[52][1], 0);
        en = 2'b10;
        step(1);
        check("drop_en_pulse_low", pout[0], 0);
        check("drop_en_running_low", prun[0], 0);
        disarm();

        // tick counter vs PPS in RUN, then reset mid-RUN
        cfg(0, 10, 10, 0, 0);
        en = 2'b01;
        arm();
        pps = 1'b0;
        step(20);
        check("run_ch0_high", pout[0], 1);
        guard = 0;
        while (dut.us_cnt_q != 5 && guard < 30) begin
            step(1);
            guard++;
        end
        check("cnt_wait_in_budget", guard < 30, 1);
        pps = 1'b1;
        step(1);
        check("cnt_at_pps_edge", 32'(dut.us_cnt_q), 6);
        step(1);
`ifdef MULTI_PULSE_PPS_RESYNC_EN
        check("cnt_after_pps", 32'(dut.us_cnt_q), 0);
`else
        check("cnt_after_pps", 32'(dut.us_cnt_q), 7);
`endif
        rst_n = 1'b0;
        step(1);
        check("midrun_rst_pulse", pout, 0);
        check("midrun_rst_running", prun, 0);
        check("midrun_rst_armed", armed, 0);
        rst_n = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
